// File: rtl/reset_pulse_bank.sv
// rtl/reset_pulse_bank.sv - multi-channel synchronised edge-to-pulse generator for reset requests
//
// Purpose: each channel synchronises an asynchronous request level, detects the
// configured edge and emits a fixed-length pulse (with optional retrigger and
// channel-0 dominance). Triggers that cannot be honoured set a sticky overrun flag.
//
// Ports:
//   piul1Clock      single clock
//   piul1Reset      synchronous active-high reset
//   piulSigIn       asynchronous request levels, one per channel
//   piulEnable      per-channel trigger enable
//   piulClearOvr    per-channel overrun-flag clear
//   poulPulse       active-high pulse per channel
//   poulPulse_n     inverse of poulPulse
//   poulOverrun     sticky dropped-trigger flag per channel
//   poul1AnyActive  OR of poulPulse
module reset_pulse_bank #(
   parameter int CHANNELS    = 3,
   parameter int SYNC_STAGES = 2,
   parameter int PULSE_LEN   = 8,
   parameter int EDGE_TYPE   = 1,
   parameter int RETRIGGER   = 0,
   parameter int DOMINANT    = 0
) (
   input  logic                piul1Clock,
   input  logic                piul1Reset,
   input  logic [CHANNELS-1:0] piulSigIn,
   input  logic [CHANNELS-1:0] piulEnable,
   input  logic [CHANNELS-1:0] piulClearOvr,
   output logic [CHANNELS-1:0] poulPulse,
   output logic [CHANNELS-1:0] poulPulse_n,
   output logic [CHANNELS-1:0] poulOverrun,
   output logic                poul1AnyActive
);

   localparam int CW = $clog2(PULSE_LEN + 1);
   localparam int AW = $clog2(SYNC_STAGES + 2);
   localparam logic [CW-1:0] RELOAD   = CW'(PULSE_LEN - 1);
   localparam logic [AW-1:0] ARM_INIT = AW'(SYNC_STAGES + 1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t              state [CHANNELS];
   logic [CW-1:0]       cnt   [CHANNELS];
   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] hist_q;
   logic [CHANNELS-1:0] pulse_q;
   logic [CHANNELS-1:0] ovr_q;
   logic [AW-1:0]       arm_cnt;

   logic [CHANNELS-1:0] edge_hit;
   logic [CHANNELS-1:0] trig_raw;
   logic [CHANNELS-1:0] trig;
   logic [CHANNELS-1:0] kill;
   logic [CHANNELS-1:0] ovr_set;
   logic                armed;

   always_comb begin
      armed = (arm_cnt == '0);
      if (EDGE_TYPE == 0)
         edge_hit = ~sync_q[SYNC_STAGES-1] & hist_q;
      else if (EDGE_TYPE == 1)
         edge_hit = sync_q[SYNC_STAGES-1] & ~hist_q;
      else
         edge_hit = sync_q[SYNC_STAGES-1] ^ hist_q;
      trig_raw = armed ? (edge_hit & piulEnable) : '0;
      trig = trig_raw;
      kill = '0;
      // Channel 0 pre-empts: its trigger knocks out the others, and while it
      // is busy (or starting) their triggers vanish without counting as overrun.
      if (DOMINANT != 0) begin
         for (int i = 1; i < CHANNELS; i++) begin
            kill[i] = trig_raw[0];
            if (trig_raw[0] || pulse_q[0])
               trig[i] = 1'b0;
         end
      end
      ovr_set = trig & pulse_q & ~kill & {CHANNELS{RETRIGGER == 0}};
   end

   always_ff @(posedge piul1Clock) begin
      if (piul1Reset) begin
         arm_cnt <= ARM_INIT;
         hist_q  <= '0;
         pulse_q <= '0;
         ovr_q   <= '0;
         for (int s = 0; s < SYNC_STAGES; s++)
            sync_q[s] <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
         end
      end else begin
         // History keeps tracking the synced level while disarmed so levels
         // present at reset release never look like edges.
         if (arm_cnt != '0)
            arm_cnt <= arm_cnt - AW'(1);
         sync_q[0] <= piulSigIn;
         for (int s = 1; s < SYNC_STAGES; s++)
            sync_q[s] <= sync_q[s-1];
         hist_q <= sync_q[SYNC_STAGES-1];
         // A simultaneous set wins over clear.
         ovr_q <= (ovr_q & ~piulClearOvr) | ovr_set;
         for (int i = 0; i < CHANNELS; i++) begin
            unique case (state[i])
               IDLE: begin
                  if (trig[i]) begin
                     state[i]   <= ACTIVE;
                     cnt[i]     <= RELOAD;
                     pulse_q[i] <= 1'b1;
                  end
               end
               ACTIVE: begin
                  if (kill[i]) begin
                     state[i]   <= IDLE;
                     cnt[i]     <= '0;
                     pulse_q[i] <= 1'b0;
                  end else if (trig[i] && (RETRIGGER != 0)) begin
                     cnt[i] <= RELOAD;
                  end else if (cnt[i] == '0) begin
                     state[i]   <= IDLE;
                     pulse_q[i] <= 1'b0;
                  end else begin
                     cnt[i] <= cnt[i] - CW'(1);
                  end
               end
            endcase
         end
      end
   end

   assign poulPulse      = pulse_q;
   assign poulPulse_n    = ~pulse_q;
   assign poulOverrun    = ovr_q;
   assign poul1AnyActive = |pulse_q;

endmodule

// File: tb/tb_reset_pulse_bank.sv
// tb/tb_reset_pulse_bank.sv - self-checking bench for reset_pulse_bank
module tb_reset_pulse_bank;

   logic       clk;
   logic       rst;
   logic [3:0] sig;
   logic [3:0] en;
   logic [3:0] clr;

   logic [2:0] p0, pn0, o0;
   logic       a0;
   logic [3:0] p1, pn1, o1;
   logic       a1;
   logic [1:0] p2, pn2, o2;
   logic       a2;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   // instance 0: defaults
   reset_pulse_bank u0 (
      .piul1Clock(clk), .piul1Reset(rst), .piulSigIn(sig[2:0]), .piulEnable(en[2:0]),
      .piulClearOvr(clr[2:0]), .poulPulse(p0), .poulPulse_n(pn0), .poulOverrun(o0),
      .poul1AnyActive(a0));

   // instance 1: falling edge, retrigger, channel-0 dominant, deeper sync
   reset_pulse_bank #(.CHANNELS(4), .SYNC_STAGES(3), .PULSE_LEN(5), .EDGE_TYPE(0),
                      .RETRIGGER(1), .DOMINANT(1)) u1 (
      .piul1Clock(clk), .piul1Reset(rst), .piulSigIn(sig), .piulEnable(en),
      .piulClearOvr(clr), .poulPulse(p1), .poulPulse_n(pn1), .poulOverrun(o1),
      .poul1AnyActive(a1));

   // instance 2: both edges, one-cycle pulses
   reset_pulse_bank #(.CHANNELS(2), .SYNC_STAGES(2), .PULSE_LEN(1), .EDGE_TYPE(2),
                      .RETRIGGER(0), .DOMINANT(0)) u2 (
      .piul1Clock(clk), .piul1Reset(rst), .piulSigIn(sig[1:0]), .piulEnable(en[1:0]),
      .piulClearOvr(clr[1:0]), .poulPulse(p2), .poulPulse_n(pn2), .poulOverrun(o2),
      .poul1AnyActive(a2));

   logic [3:0] op [3];
   logic [3:0] on [3];
   logic [3:0] oo [3];
   logic       oa [3];
   assign op[0] = {1'b0, p0};  assign on[0] = {1'b0, pn0}; assign oo[0] = {1'b0, o0}; assign oa[0] = a0;
   assign op[1] = p1;          assign on[1] = pn1;         assign oo[1] = o1;         assign oa[1] = a1;
   assign op[2] = {2'b0, p2};  assign on[2] = {2'b0, pn2}; assign oo[2] = {2'b0, o2}; assign oa[2] = a2;

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic int c_ch(input int n);
      return (n == 0) ? 3 : (n == 1) ? 4 : 2;
   endfunction
   function automatic int c_s(input int n);
      return (n == 1) ? 3 : 2;
   endfunction
   function automatic int c_pl(input int n);
      return (n == 0) ? 8 : (n == 1) ? 5 : 1;
   endfunction
   function automatic int c_et(input int n);
      return (n == 0) ? 1 : (n == 1) ? 0 : 2;
   endfunction
   function automatic bit c_rt(input int n);
      return n == 1;
   endfunction
   function automatic bit c_dm(input int n);
      return n == 1;
   endfunction

   // Reference model: per-edge sample history, cycles since reset release,
   // and the number of high cycles each pulse still owes.
   logic [3:0] dl  [3][6];
   int         rel [3];
   int         rem [3][4];
   bit         ovr_m [3][4];

   task automatic model_step(input int n);
      int  s, pl;
      logic [3:0] trg;
      bit  armed, c, p, hit, act0, t0, mt, kl, st;
      s  = c_s(n);
      pl = c_pl(n);
      if (rst) begin
         for (int k = 0; k < 6; k++) dl[n][k] = '0;
         rel[n] = 0;
         for (int i = 0; i < 4; i++) begin
            rem[n][i]   = 0;
            ovr_m[n][i] = 0;
         end
      end else begin
         for (int k = 5; k > 0; k--) dl[n][k] = dl[n][k-1];
         dl[n][0] = sig;
         if (rel[n] < 1000) rel[n]++;
         // the level sampled s edges ago becomes actionable now; no triggers
         // until s+1 edges have passed since release
         armed = rel[n] >= s + 2;
         trg = '0;
         for (int i = 0; i < c_ch(n); i++) begin
            c = dl[n][s][i];
            p = dl[n][s+1][i];
            hit = (c_et(n) == 0) ? (!c && p) : (c_et(n) == 1) ? (c && !p) : (c != p);
            trg[i] = armed && en[i] && hit;
         end
         act0 = rem[n][0] > 0;
         t0   = trg[0];
         for (int i = 0; i < c_ch(n); i++) begin
            mt = trg[i] && !(c_dm(n) && i > 0 && (act0 || t0));
            kl = c_dm(n) && i > 0 && t0;
            st = 0;
            if (kl) rem[n][i] = 0;
            else if (rem[n][i] > 0) begin
               if (mt && c_rt(n)) rem[n][i] = pl;
               else begin
                  if (mt) st = 1;
                  rem[n][i]--;
               end
            end else if (mt) rem[n][i] = pl;
            ovr_m[n][i] = (ovr_m[n][i] && !clr[i]) || st;
         end
      end
   endtask

   function automatic logic [3:0] exp_p(input int n);
      logic [3:0] r = '0;
      for (int i = 0; i < c_ch(n); i++) r[i] = rem[n][i] > 0;
      return r;
   endfunction
   function automatic logic [3:0] exp_o(input int n);
      logic [3:0] r = '0;
      for (int i = 0; i < c_ch(n); i++) r[i] = ovr_m[n][i];
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) chk_en = 1;
      for (int n = 0; n < 3; n++) model_step(n);
   end

   task automatic chk(input string name, input int n, input logic [3:0] act, input logic [3:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d t=%0t actual=%h required=%h", name, n, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin : cmp_proc
      logic [3:0] m;
      if (chk_en) begin
         for (int n = 0; n < 3; n++) begin
            m = 4'((1 << c_ch(n)) - 1);
            chk("pulse", n, op[n] & m, exp_p(n));
            chk("pulse_n", n, on[n] & m, ~exp_p(n) & m);
            chk("overrun", n, oo[n] & m, exp_o(n));
            chk("any_active", n, {3'b0, oa[n]}, {3'b0, |exp_p(n)});
         end
      end
   end

   task automatic tick;
      @(negedge clk);
   endtask

   int hi;

   initial begin
      rst = 1; sig = 4'hF; en = 4'hF; clr = 4'h0;
      repeat (3) tick;

      // levels held through reset release produce nothing
      rst = 0;
      repeat (50) begin
         tick;
         chk("quiet_after_reset", 0, {1'b0, a0, a1, a2}, 4'h0);
      end

      // rising edge on ch1: sampled at edge E, high after edges E+2..E+9
      sig = 4'h0;
      repeat (10) tick;
      sig = 4'b0010;
      for (int k = 1; k <= 11; k++) begin
         tick;
         chk("ch1_pulse_window", 0, {3'b0, p0[1]}, {3'b0, (k >= 3 && k <= 10)});
         chk("ch1_pulse_n_window", 0, {3'b0, pn0[1]}, {3'b0, !(k >= 3 && k <= 10)});
      end
      sig = 4'h0;
      repeat (12) tick;

      // second rising edge 4 cycles into the pulse, no retrigger
      hi = 0;
      sig = 4'b0001;
      repeat (2) begin tick; hi += p0[0]; end
      sig = 4'b0000;
      repeat (2) begin tick; hi += p0[0]; end
      sig = 4'b0001;
      repeat (12) begin tick; hi += p0[0]; end
      chk("no_retrigger_len", 0, 4'(hi), 4'd8);
      chk("overrun_set", 0, {3'b0, o0[0]}, 4'h1);
      clr = 4'b0001;
      tick;
      clr = 4'b0000;
      chk("overrun_cleared", 0, {3'b0, o0[0]}, 4'h0);
      sig = 4'h0;

      // randomized traffic, slow then fast toggling
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(0, (c < 2000) ? 7 : 2) == 0) sig[b] = ~sig[b];
         if ($urandom_range(0, 19) == 0) en = 4'($urandom);
         clr = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'h0;
         rst = ($urandom_range(0, 499) == 0);
         tick;
      end

      // reset in the middle of a pulse drops it at that edge
      rst = 0; en = 4'hF; clr = 4'h0; sig = 4'h0;
      repeat (12) tick;
      sig = 4'b0001;
      repeat (4) tick;
      chk("pulse_before_reset", 0, {3'b0, p0[0]}, 4'h1);
      rst = 1;
      tick;
      chk("pulse_after_reset", 0, {1'b0, p0}, 4'h0);
      chk("pulse_n_after_reset", 0, {1'b0, pn0}, 4'h7);
      chk("any_after_reset", 0, {3'b0, a0}, 4'h0);
      rst = 0;
      sig = 4'h0;
      repeat (12) tick;

      // both-edge one-cycle pulses, then masked by enable
      hi = 0;
      for (int t = 0; t < 8; t++) begin
         sig[0] = ~sig[0];
         repeat (4) begin tick; hi += p2[0]; end
      end
      repeat (6) begin tick; hi += p2[0]; end
      chk("toggle_pulses", 2, 4'(hi), 4'd8);
      hi = 0;
      en = 4'h0;
      for (int t = 0; t < 8; t++) begin
         sig[0] = ~sig[0];
         repeat (4) begin tick; hi += p2[0]; end
      end
      repeat (6) begin tick; hi += p2[0]; end
      chk("toggle_disabled", 2, 4'(hi), 4'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reset_pulse_bank.md
RESET_PULSE_BANK -- requirements
Module: reset_pulse_bank

Interface
REQ-001 SHALL have parameter CHANNELS, default 3: number of independent trigger channels (1..16).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth per input (2..4).
REQ-003 SHALL have parameter PULSE_LEN, default 8: output pulse length in clock cycles (1..255).
REQ-004 SHALL have parameter EDGE_TYPE, default 1: 0 = falling, 1 = rising, 2 = both edges.
REQ-005 SHALL have parameter RETRIGGER, default 0: 1 = a trigger during an active pulse restarts it.
REQ-006 SHALL have parameter DOMINANT, default 0: 1 = channel 0 pre-empts all other channels.
REQ-007 SHALL have port piul1Clock, input, 1 bit: the single clock.
REQ-008 SHALL have port piul1Reset, input, 1 bit: synchronous, active-high reset.
REQ-009 SHALL have port piulSigIn, input, CHANNELS bits: asynchronous request levels.
REQ-010 SHALL have port piulEnable, input, CHANNELS bits: per-channel trigger enable (synchronous).
REQ-011 SHALL have port piulClearOvr, input, CHANNELS bits: per-channel overrun-flag clear (synchronous).
REQ-012 SHALL have port poulPulse, output, CHANNELS bits: active-high pulse.
REQ-013 SHALL have port poulPulse_n, output, CHANNELS bits: bitwise inverse of poulPulse, for active-low reset requests.
REQ-014 SHALL have port poulOverrun, output, CHANNELS bits: sticky flag, set when a trigger is dropped.
REQ-015 SHALL have port poul1AnyActive, output, 1 bit: OR of poulPulse.

Function
REQ-016 Each input SHALL pass through a SYNC_STAGES-deep flop chain, followed by one history register.
REQ-017 A trigger SHALL be a synced-value vs history mismatch that matches EDGE_TYPE, gated by piulEnable[i] in that cycle.
REQ-018 Latency: input sampled by the first sync flop at edge k -> poulPulse[i] high from edge k+SYNC_STAGES.
REQ-019 Per channel, the FSM SHALL have states IDLE and ACTIVE, with a counter of width clog2(PULSE_LEN+1).
REQ-020 IDLE + trigger -> ACTIVE: counter loaded with PULSE_LEN-1, pulse high.
REQ-021 In ACTIVE, the counter SHALL decrement each cycle; ACTIVE with counter 0 -> IDLE, pulse low on the next edge.
REQ-022 Net effect of REQ-020/021: pulse high for exactly PULSE_LEN cycles.
REQ-023 PULSE_LEN=1 SHALL give a one-cycle pulse; back-to-back triggers SHALL produce separate pulses with no merge requirement beyond RETRIGGER.
REQ-024 Trigger in ACTIVE with RETRIGGER=1: counter reloads to PULSE_LEN-1; the pulse stays high for PULSE_LEN cycles after that trigger; no overrun.
REQ-025 Trigger in ACTIVE with RETRIGGER=0: trigger ignored, poulOverrun[i] set on the next edge.
REQ-026 Trigger in the last ACTIVE cycle (counter 0) SHALL be handled per REQ-024/025, never as a new IDLE trigger.
REQ-027 poulOverrun[i] SHALL be cleared by piulClearOvr[i]; a simultaneous set and clear SHALL leave it set.
REQ-028 piulEnable deasserted mid-pulse SHALL NOT shorten the pulse; it only masks new triggers.
REQ-029 DOMINANT=1, channel 0 trigger: all other channels go to IDLE on the next edge, pulses drop.
REQ-030 DOMINANT=1, while channel 0 is ACTIVE: other-channel triggers are discarded without setting overrun.
REQ-031 DOMINANT=0: channels fully independent.
REQ-032 All outputs SHALL be registered or derived by inversion/OR of registered state only.

Reset
REQ-033 piul1Reset has priority over all other inputs.
REQ-034 On reset: sync chains and history cleared to 0, all FSMs IDLE, counters 0.
REQ-035 On reset: poulPulse=0, poulPulse_n=all 1, poulOverrun=0, poul1AnyActive=0.
REQ-036 Reset asserted mid-pulse SHALL drop the pulse at the next edge.
REQ-037 After reset deassertion, an arming counter SHALL suppress triggers for SYNC_STAGES+1 cycles, with the history register tracking the synced value.
REQ-038 Consequence of REQ-037: levels already present at reset release SHALL generate no pulse.

Verification
REQ-039 Defaults; SigIn[1] 0->1 sampled at edge 10 -> Pulse[1] high edges 12..19 (8 cycles), Pulse_n[1] low for the same cycles, AnyActive tracks.
REQ-040 RETRIGGER=0, PULSE_LEN=8; second rising edge on ch0 4 cycles into the pulse -> pulse still ends after 8 cycles, Overrun[0]=1; ClearOvr[0] -> 0.
REQ-041 RETRIGGER=1; retrigger 4 cycles into the pulse -> 12 total high cycles, Overrun stays 0.
REQ-042 DOMINANT=1; ch2 active 3 cycles, then ch0 triggers -> Pulse[2] low next edge; ch1 trigger during the ch0 pulse -> no pulse, Overrun[1]=0.
REQ-043 SigIn all 1 through reset, reset released -> no pulses for 50 cycles; reset asserted mid-pulse -> Pulse=0 next edge.
REQ-044 EDGE_TYPE=2, PULSE_LEN=1; SigIn toggles every 4 cycles -> one 1-cycle pulse per toggle; Enable=0 -> none.
